ttc_capture_lite25: RTL and testbench

- Input-capture companion to the TTC counter/waveform generator, sitting in the same timer channel.
- Where the counter block drives a waveform out, this block receives an external waveform and measures it. It gives the period (same edge to same edge) or the pulse width (edge to opposite edge), counted in prescaler ticks (count_en25).
- It raises a capture interrupt on each completed measurement and an overflow interrupt when the measurement timer saturates.

---
 rtl/ttc_capture_lite25.sv | 193 +++++++++++++++++++
 tb/tb_ttc_capture_lite25.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_capture_lite25.sv
// ttc_capture_lite25: input-capture channel of the TTC timer.
// Measures the period (same edge to same edge) or the pulse width (edge to
// opposite edge) of wave_in25 in prescaler ticks (count_en25). It pulses
// capt_intr25 on each completed measurement and capt_ovf_intr25 when the
// measurement timer saturates.
// Optional build macro: TTC_CAPT_GLITCH_FILTER_EN adds a 3-sample stability
// filter after the synchronizer. This adds 2 cycles of detection latency.
module ttc_capture_lite25 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        pclk25,
  input  logic        n_p_reset25,
  input  logic [15:0] pwdata25,
  input  logic        count_en25,
  input  logic        capt_ctrl_reg_sel25,
  input  logic        wave_in25,
  output logic [5:0]  capt_ctrl_reg_out25,
  output logic [15:0] capture_val_out25,
  output logic [15:0] edge_cnt_out25,
  output logic        capt_busy25,
  output logic        capt_intr25,
  output logic        capt_ovf_intr25
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last;
  logic                   lvl_cur;
  logic                   lvl_prev;

  logic [5:0]  ctrl_q,  ctrl_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] cap_q,   cap_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        intr_q,  intr_d;
  logic        ovf_q,   ovf_d;

  logic        rise, fall, active, terminal;
  logic        sat;
  logic [15:0] tick;
  logic        unused_pwdata;

  assign unused_pwdata = ^pwdata25[15:6];
  assign sync_last     = sync_q[SYNC_STAGES-1];

  // Metastability chain on the asynchronous input.
  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      sync_q <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wave_in25};
    end else begin
      sync_q <= wave_in25;
    end
  end

`ifdef TTC_CAPT_GLITCH_FILTER_EN
  logic [1:0] samp_q;
  logic       filt_q;

  // Filtered level moves only once three consecutive samples agree;
  // filt_q doubles as the edge-detect history.
  assign lvl_cur  = (sync_last == samp_q[0] && sync_last == samp_q[1]) ? sync_last : filt_q;
  assign lvl_prev = filt_q;

  // Sample history and filtered-level register.
  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      samp_q <= '0;
      filt_q <= 1'b0;
    end else begin
      samp_q <= {samp_q[0], sync_last};
      filt_q <= lvl_cur;
    end
  end
`else
  logic hist_q;

  assign lvl_cur  = sync_last;
  assign lvl_prev = hist_q;

  // History flop for edge detection.
  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= sync_last;
    end
  end
`endif

  assign rise     = ~lvl_prev & lvl_cur;
  assign fall     = lvl_prev & ~lvl_cur;
  assign active   = ctrl_q[1] ? fall : rise;
  assign terminal = ctrl_q[2] ? (ctrl_q[1] ? rise : fall) : active;
  assign tick     = {15'd0, count_en25};
  // A tick arriving at FFFE is the saturating transition; a terminal edge in
  // that same cycle captures the saturated value.
  assign sat      = count_en25 && (timer_q == 16'hFFFE);

  // Next-state logic: disable write first, then pending restart, then
  // release from HOLD by a write, then normal measurement flow.
  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    intr_d  = 1'b0;
    ovf_d   = 1'b0;

    if (capt_ctrl_reg_sel25) begin
      ctrl_d = pwdata25[5:0];
    end else if (ctrl_q[4]) begin
      ctrl_d[4] = 1'b0;
    end

    if (capt_ctrl_reg_sel25 && pwdata25[0]) begin
      state_d = ST_IDLE;
    end else if (ctrl_q[4]) begin
      timer_d = '0;
      cnt_d   = '0;
      state_d = ctrl_q[0] ? ST_IDLE : ST_ARMED;
    end else if (capt_ctrl_reg_sel25 && (state_q == ST_HOLD)) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ctrl_q[0]) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (active) begin
            timer_d = tick;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          ovf_d = sat;
          if (terminal) begin
            cap_d  = sat ? 16'hFFFF : timer_q;
            cnt_d  = cnt_q + 16'd1;
            intr_d = 1'b1;
            if (ctrl_q[3]) begin
              state_d = ST_HOLD;
            end else if (!ctrl_q[2]) begin
              timer_d = tick;
            end else begin
              state_d = ST_ARMED;
            end
          end else if (timer_q != 16'hFFFF) begin
            timer_d = timer_q + tick;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control, measurement and interrupt registers.
  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      ctrl_q  <= 6'b000001;
      state_q <= ST_IDLE;
      timer_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      intr_q  <= intr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign capt_ctrl_reg_out25 = ctrl_q;
  assign capture_val_out25   = cap_q;
  assign edge_cnt_out25      = cnt_q;
  assign capt_busy25         = (state_q == ST_MEASURE);
  assign capt_intr25         = intr_q;
  assign capt_ovf_intr25     = ovf_q;

endmodule

// File: tb/tb_ttc_capture_lite25.sv
// Testbench for ttc_capture_lite25: directed scenarios plus randomized
// stimulus, compared every cycle against a behavioural reference model.
module tb_ttc_capture_lite25;

  localparam int unsigned SYNC_STAGES = 2;

  logic        pclk25 = 1'b0;
  logic        n_p_reset25 = 1'b0;
  logic [15:0] pwdata25 = '0;
  logic        count_en25 = 1'b1;
  logic        capt_ctrl_reg_sel25 = 1'b0;
  logic        wave_in25 = 1'b0;
  logic [5:0]  capt_ctrl_reg_out25;
  logic [15:0] capture_val_out25;
  logic [15:0] edge_cnt_out25;
  logic        capt_busy25;
  logic        capt_intr25;
  logic        capt_ovf_intr25;

  int checks = 0;
  int failures = 0;
  int intr_seen = 0;
  int ovf_seen = 0;
  int en_mode = 0;
  int ph = 0;

  ttc_capture_lite25 #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .pclk25              (pclk25),
    .n_p_reset25         (n_p_reset25),
    .pwdata25            (pwdata25),
    .count_en25          (count_en25),
    .capt_ctrl_reg_sel25 (capt_ctrl_reg_sel25),
    .wave_in25           (wave_in25),
    .capt_ctrl_reg_out25 (capt_ctrl_reg_out25),
    .capture_val_out25   (capture_val_out25),
    .edge_cnt_out25      (edge_cnt_out25),
    .capt_busy25         (capt_busy25),
    .capt_intr25         (capt_intr25),
    .capt_ovf_intr25     (capt_ovf_intr25)
  );

  always #5 pclk25 = ~pclk25;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PH_OFF = 0, PH_WAIT = 1, PH_MEAS = 2, PH_FROZEN = 3;
  logic [5:0]  m_ctrl;
  logic [15:0] m_cap, m_cnt;
  logic        m_intr, m_ovf;
  int          m_phase;
  int          ticks;
  bit          seen[$];

  function automatic void model_reset();
    m_ctrl = 6'b000001; m_cap = '0; m_cnt = '0;
    m_intr = 1'b0; m_ovf = 1'b0; m_phase = PH_OFF; ticks = 0;
    seen.delete();
    for (int i = 0; i < SYNC_STAGES + 1; i++) seen.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit cur, prev, up, down, act_e, term_e, sat_now;
    logic [5:0] old;
    int en;
    old  = m_ctrl;
    en   = count_en25 ? 1 : 0;
    // level seen by the edge detector is the input delayed by the sync depth
    prev = seen[0];
    cur  = seen[1];
    void'(seen.pop_front());
    seen.push_back(wave_in25);
    up     = !prev && cur;
    down   = prev && !cur;
    act_e  = old[1] ? down : up;
    term_e = old[2] ? (old[1] ? up : down) : act_e;
    m_intr = 1'b0;
    m_ovf  = 1'b0;
    if (capt_ctrl_reg_sel25) m_ctrl = pwdata25[5:0];
    else if (old[4])         m_ctrl[4] = 1'b0;
    if (capt_ctrl_reg_sel25 && pwdata25[0]) begin
      m_phase = PH_OFF;
    end else if (old[4]) begin
      ticks = 0; m_cnt = 16'd0;
      m_phase = old[0] ? PH_OFF : PH_WAIT;
    end else if (capt_ctrl_reg_sel25 && m_phase == PH_FROZEN) begin
      m_phase = PH_WAIT;
    end else if (m_phase == PH_OFF) begin
      if (!old[0]) m_phase = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (act_e) begin ticks = en; m_phase = PH_MEAS; end
    end else if (m_phase == PH_MEAS) begin
      sat_now = (en == 1) && (ticks == 65534);
      m_ovf = sat_now;
      if (term_e) begin
        m_cap  = sat_now ? 16'hFFFF : 16'((ticks > 65535) ? 65535 : ticks);
        m_cnt  = m_cnt + 16'd1;
        m_intr = 1'b1;
        if (old[3])      m_phase = PH_FROZEN;
        else if (!old[2]) ticks = en;
        else             m_phase = PH_WAIT;
      end else begin
        ticks = ticks + en;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge pclk25 or negedge n_p_reset25);
      if (!n_p_reset25) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge pclk25);
      chk("ctrl", 32'(capt_ctrl_reg_out25), 32'(m_ctrl));
      chk("capture_val", 32'(capture_val_out25), 32'(m_cap));
      chk("edge_cnt", 32'(edge_cnt_out25), 32'(m_cnt));
      chk("busy", 32'(capt_busy25), 32'(m_phase == PH_MEAS));
      chk("capt_intr", 32'(capt_intr25), 32'(m_intr));
      chk("ovf_intr", 32'(capt_ovf_intr25), 32'(m_ovf));
      if (capt_intr25) intr_seen++;
      if (capt_ovf_intr25) ovf_seen++;
    end
  end

  // Prescaler tick source.
  initial begin
    forever begin
      @(posedge pclk25);
      #1;
      ph = (ph + 1) % 4;
      case (en_mode)
        0:       count_en25 = 1'b1;
        1:       count_en25 = (ph == 0);
        default: count_en25 = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk25);
    #1;
  endtask

  task automatic wr(input logic [5:0] d);
    capt_ctrl_reg_sel25 = 1'b1;
    pwdata25 = {10'd0, d};
    tick(1);
    capt_ctrl_reg_sel25 = 1'b0;
  endtask

  int i0, o0;
  bit rnd_rst;
  int hold;

  initial begin
    tick(3);
    chk("rst_ctrl", 32'(capt_ctrl_reg_out25), 32'h01);
    chk("rst_cap", 32'(capture_val_out25), 32'h0);
    chk("rst_cnt", 32'(edge_cnt_out25), 32'h0);
    chk("rst_busy", 32'(capt_busy25), 32'h0);
    n_p_reset25 = 1'b1;
    tick(2);

    // Period mode, rising edges every 20 pclk.
    wr(6'b000000);
    i0 = intr_seen;
    for (int p = 0; p < 4; p++) begin
      wave_in25 = 1'b1;
      tick(5);
      if (p > 0) begin
        chk("period_cnt", 32'(edge_cnt_out25), 32'(p));
        chk("period_val", 32'(capture_val_out25), 32'd20);
      end
      tick(5);
      wave_in25 = 1'b0;
      tick(10);
    end
    chk("period_intr_pulses", 32'(intr_seen - i0), 32'd3);

    // Width mode, falling edge, 7-pclk low pulse.
    wr(6'b000001);
    wave_in25 = 1'b1;
    tick(5);
    wr(6'b000110);
    tick(2);
    wave_in25 = 1'b0;
    tick(7);
    wave_in25 = 1'b1;
    tick(6);
    chk("width_val", 32'(capture_val_out25), 32'd7);
    chk("width_cnt", 32'(edge_cnt_out25), 32'd4);
    chk("width_armed", 32'(capt_busy25), 32'd0);

    // Prescaled ticks: 1 in 4, period 40.
    wr(6'b000001);
    wave_in25 = 1'b0;
    en_mode = 1;
    tick(3);
    wr(6'b000000);
    for (int p = 0; p < 3; p++) begin
      wave_in25 = 1'b1;
      tick(5);
      if (p > 0) chk("presc_val", 32'(capture_val_out25), 32'd10);
      tick(15);
      wave_in25 = 1'b0;
      tick(20);
    end

    // Overflow: no second edge for well beyond 65535 ticks.
    en_mode = 0;
    wr(6'b000001);
    tick(3);
    wr(6'b000000);
    o0 = ovf_seen;
    wave_in25 = 1'b1;
    tick(10);
    wave_in25 = 1'b0;
    tick(65540);
    chk("ovf_pulses", 32'(ovf_seen - o0), 32'd1);
    chk("ovf_busy", 32'(capt_busy25), 32'd1);
    wave_in25 = 1'b1;
    tick(5);
    chk("ovf_capture", 32'(capture_val_out25), 32'hFFFF);
    chk("ovf_pulses_after", 32'(ovf_seen - o0), 32'd1);
    chk("ovf_cnt", 32'(edge_cnt_out25), 32'd7);

    // One-shot then restart.
    wr(6'b010001);
    wave_in25 = 1'b0;
    tick(3);
    chk("restart_idle_cnt", 32'(edge_cnt_out25), 32'd0);
    wr(6'b001000);
    for (int p = 0; p < 3; p++) begin
      wave_in25 = 1'b1;
      tick(10);
      wave_in25 = 1'b0;
      tick(10);
    end
    chk("oneshot_cnt", 32'(edge_cnt_out25), 32'd1);
    chk("oneshot_val", 32'(capture_val_out25), 32'd20);
    chk("oneshot_hold", 32'(capt_busy25), 32'd0);
    wr(6'b011000);
    chk("restart_written", 32'(capt_ctrl_reg_out25), 32'b011000);
    tick(1);
    chk("restart_cnt", 32'(edge_cnt_out25), 32'd0);
    chk("restart_bit4", 32'(capt_ctrl_reg_out25), 32'b001000);
    chk("restart_val_kept", 32'(capture_val_out25), 32'd20);
    chk("restart_armed", 32'(capt_busy25), 32'd0);

    // Reset mid-measurement.
    wr(6'b000000);
    wave_in25 = 1'b1;
    tick(5);
    chk("meas_busy", 32'(capt_busy25), 32'd1);
    n_p_reset25 = 1'b0;
    #2;
    chk("mid_rst_ctrl", 32'(capt_ctrl_reg_out25), 32'h01);
    chk("mid_rst_cap", 32'(capture_val_out25), 32'h0);
    chk("mid_rst_cnt", 32'(edge_cnt_out25), 32'h0);
    chk("mid_rst_busy", 32'(capt_busy25), 32'h0);
    chk("mid_rst_intr", 32'({capt_intr25, capt_ovf_intr25}), 32'h0);
    tick(2);
    n_p_reset25 = 1'b1;

    // Disable mid-period.
    wave_in25 = 1'b0;
    tick(3);
    wr(6'b000000);
    tick(2);
    wave_in25 = 1'b1;
    tick(10);
    i0 = intr_seen;
    wave_in25 = 1'b0;
    tick(5);
    wr(6'b000001);
    chk("disable_busy", 32'(capt_busy25), 32'd0);
    wave_in25 = 1'b1;
    tick(10);
    wave_in25 = 1'b0;
    tick(5);
    chk("disable_no_intr", 32'(intr_seen - i0), 32'd0);
    chk("disable_idle", 32'(capt_busy25), 32'd0);

    // Randomized traffic.
    en_mode = 2;
    wr(6'b000000);
    hold = 1;
    for (int c = 0; c < 4000; c++) begin
      hold--;
      if (hold <= 0) begin
        wave_in25 = ~wave_in25;
        hold = int'($urandom_range(1, 14));
      end
      rnd_rst = ($urandom_range(0, 999) == 0);
      n_p_reset25 = ~rnd_rst;
      if ($urandom_range(0, 99) < 3) begin
        capt_ctrl_reg_sel25 = 1'b1;
        pwdata25 = 16'($urandom);
        pwdata25[0] = ($urandom_range(0, 7) == 0);
      end else begin
        capt_ctrl_reg_sel25 = 1'b0;
      end
      tick(1);
    end
    capt_ctrl_reg_sel25 = 1'b0;
    n_p_reset25 = 1'b1;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
